// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types and constants: FSM state encoding and PC arithmetic offsets.
package ifetch_pkg;
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } ifetch_state_e;

  localparam logic [31:0] PC_INC      = 32'd4;
  localparam logic [31:0] PIPE_OFFSET = 32'd8;
endpackage

// File: rtl/ifetch32.sv
// Instruction fetch stage: owns the PC, registers the fetched word for the decoder, and squashes one slot per taken branch.
// Optional performance counters are compiled in with `define IFETCH_PERF_EN.
module ifetch32
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] iout,
  output logic        ispb_out,
  output logic [31:0] ir_pc,
  input  logic        ib_in,
  input  logic        bl_in,
  input  logic [31:0] bv_in,
  output logic        link_we,
  output logic [31:0] link_data
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_squash
`endif
);

  ifetch_state_e r_state, w_state_nx;
  logic [31:0]   r_pc, w_pc_nx;
  logic [31:0]   r_iout, w_iout_nx;
  logic [31:0]   r_ir_pc, w_ir_pc_nx;
  logic          r_ispb, w_ispb_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_pc    <= RESET_PC;
      r_iout  <= NOP_INSTR;
      r_ir_pc <= 32'd0;
      r_ispb  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_iout  <= w_iout_nx;
      r_ir_pc <= w_ir_pc_nx;
      r_ispb  <= w_ispb_nx;
    end
  end

  // A stalled cycle leaves every default in place, so a held branch is applied on release.
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx    = r_pc;
    w_iout_nx  = r_iout;
    w_ir_pc_nx = r_ir_pc;
    w_ispb_nx  = r_ispb;
    if (!stall) begin
      case (r_state)
        FILL: begin
          w_iout_nx  = imem_rdata;
          w_ir_pc_nx = r_pc;
          w_pc_nx    = r_pc + PC_INC;
          w_ispb_nx  = 1'b0;
          w_state_nx = RUN;
        end
        RUN: begin
          w_iout_nx  = imem_rdata;
          w_ir_pc_nx = r_pc;
          if (ib_in) begin
            w_pc_nx    = r_ir_pc + PIPE_OFFSET + bv_in;
            w_ispb_nx  = 1'b1;
            w_state_nx = FLUSH;
          end else begin
            w_pc_nx    = r_pc + PC_INC;
            w_ispb_nx  = 1'b0;
          end
        end
        FLUSH: begin
          w_iout_nx  = imem_rdata;
          w_ir_pc_nx = r_pc;
          w_pc_nx    = r_pc + PC_INC;
          w_ispb_nx  = 1'b0;
          w_state_nx = RUN;
        end
        default: w_state_nx = FILL;
      endcase
    end
  end

  assign imem_addr = {r_pc[31:2], 2'b00};
  assign iout      = r_iout;
  assign ispb_out  = r_ispb;
  assign ir_pc     = r_ir_pc;
  assign link_we   = ib_in & bl_in & ~stall & (r_state == RUN);
  assign link_data = r_ir_pc + PC_INC;

`ifdef IFETCH_PERF_EN
  logic [31:0] r_perf_fetch, r_perf_squash;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch  <= 32'd0;
      r_perf_squash <= 32'd0;
    end else if (!stall) begin
      if (r_state == RUN || r_state == FLUSH)
        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (r_state == RUN && ib_in)
        r_perf_squash <= r_perf_squash + 32'd1;
    end
  end

  assign perf_fetch  = r_perf_fetch;
  assign perf_squash = r_perf_squash;
`endif

endmodule

// File: tb/tb_ifetch32.sv
// Directed bench for ifetch32: reset, straight-line fetch, branches, link, stall hold, PC wrap, reset mid-flush.
module tb_ifetch32;
  logic        clk = 1'b0;
  logic        rst, stall, ib_in, bl_in;
  logic [31:0] bv_in, imem_addr, imem_rdata, iout, ir_pc, link_data;
  logic        ispb_out, link_we;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetch, perf_squash;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'd0) return 32'hE081_1002;
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_rdata = rom(imem_addr);

  ifetch32 dut (
    .clk(clk), .rst(rst), .stall(stall),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .iout(iout), .ispb_out(ispb_out), .ir_pc(ir_pc),
    .ib_in(ib_in), .bl_in(bl_in), .bv_in(bv_in),
    .link_we(link_we), .link_data(link_data)
`ifdef IFETCH_PERF_EN
    , .perf_fetch(perf_fetch), .perf_squash(perf_squash)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; ib_in = 1'b0; bl_in = 1'b0; bv_in = 32'd0;
    // 1 reset
    tick(); tick();
    chk("rst_iout", iout, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_irpc", ir_pc, 32'h0);
    chk("rst_ispb", {31'd0, ispb_out}, 32'd0);
    chk("rst_lwe", {31'd0, link_we}, 32'd0);
    rst = 1'b0;
    tick();
    chk("fill_iout", iout, 32'hE081_1002);
    chk("fill_irpc", ir_pc, 32'h0);
    chk("fill_addr", imem_addr, 32'h4);
    // 2 straight line
    tick();
    chk("seq_addr8", imem_addr, 32'h8);
    chk("seq_irpc4", ir_pc, 32'h4);
    chk("seq_iout4", iout, 32'hFFFB_0004);
    tick();
    chk("seq_addrC", imem_addr, 32'hC);
    chk("seq_irpc8", ir_pc, 32'h8);
    // 3 forward branch from ir_pc=8
    ib_in = 1'b1; bv_in = 32'h10;
    #1 chk("fwd_lwe_nobl", {31'd0, link_we}, 32'd0);
    tick();
    ib_in = 1'b0;
    chk("fwd_ispb", {31'd0, ispb_out}, 32'd1);
    chk("fwd_pc", imem_addr, 32'h20);
    chk("fwd_slot", iout, 32'hFFF3_000C);
    tick();
    chk("fwd_tgt", iout, 32'hFFDF_0020);
    chk("fwd_ispb0", {31'd0, ispb_out}, 32'd0);
    chk("fwd_irpc", ir_pc, 32'h20);
    chk("fwd_addr", imem_addr, 32'h24);
    // 4 backward branch with link from ir_pc=0x40
    for (int i = 0; i < 8; i++) tick();
    chk("bk_irpc", ir_pc, 32'h40);
    ib_in = 1'b1; bl_in = 1'b1; bv_in = 32'hFFFF_FFF0;
    #1;
    chk("bk_lwe", {31'd0, link_we}, 32'd1);
    chk("bk_ldata", link_data, 32'h44);
    tick();
    chk("bk_pc", imem_addr, 32'h38);
    chk("bk_ispb", {31'd0, ispb_out}, 32'd1);
    chk("flush_lwe", {31'd0, link_we}, 32'd0);
    ib_in = 1'b0; bl_in = 1'b0;
    tick();
    chk("bk_tgt", iout, 32'hFFC7_0038);
    chk("bk_irpc2", ir_pc, 32'h38);
    // 5 stall with pending branch
    stall = 1'b1; ib_in = 1'b1; bl_in = 1'b1; bv_in = 32'h100;
    #1 chk("st_lwe", {31'd0, link_we}, 32'd0);
    tick();
    chk("st_pc1", imem_addr, 32'h3C);
    tick(); tick();
    chk("st_pc3", imem_addr, 32'h3C);
    chk("st_iout", iout, 32'hFFC7_0038);
    chk("st_ispb", {31'd0, ispb_out}, 32'd0);
    stall = 1'b0;
    #1 chk("st_rel_lwe", {31'd0, link_we}, 32'd1);
    tick();
    chk("st_redir", imem_addr, 32'h140);
    chk("st_ispb1", {31'd0, ispb_out}, 32'd1);
    chk("st_slot", iout, 32'hFFC3_003C);
    ib_in = 1'b0; bl_in = 1'b0;
    tick();
    chk("st_tgt", iout, 32'hFEBF_0140);
    // 6 wrap to 0, then reset during FLUSH
    ib_in = 1'b1; bv_in = 32'hFFFF_FEB4;
    tick();
    chk("wr_top", imem_addr, 32'hFFFF_FFFC);
    ib_in = 1'b0;
    tick();
    chk("wr_zero", imem_addr, 32'h0);
    chk("wr_irpc", ir_pc, 32'hFFFF_FFFC);
    ib_in = 1'b1; bv_in = 32'h0;
    tick();
    chk("wr_tgt", imem_addr, 32'h4);
    chk("wr_ispb", {31'd0, ispb_out}, 32'd1);
    ib_in = 1'b0; rst = 1'b1;
    tick();
    chk("rf_pc", imem_addr, 32'h0);
    chk("rf_ispb", {31'd0, ispb_out}, 32'd0);
    chk("rf_iout", iout, 32'h0);
    chk("rf_irpc", ir_pc, 32'h0);
    // branch request in FILL is ignored
    rst = 1'b0; ib_in = 1'b1; bl_in = 1'b1; bv_in = 32'h40;
    #1 chk("fl_lwe", {31'd0, link_we}, 32'd0);
    tick();
    chk("fl_addr", imem_addr, 32'h4);
    chk("fl_ispb", {31'd0, ispb_out}, 32'd0);
    chk("fl_iout", iout, 32'hE081_1002);
    ib_in = 1'b0; bl_in = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
